uart_transmitter: RTL

Serial UART transmitter for the 8N1 link, clocked by the 16x-oversampled baud clock (Clk_16_9600) that also drives the receive path.
Accepts parallel bytes from the CPU peripheral bus and shifts them out LSB-first on UART_TX.
A one-entry holding register allows back-to-back frames with no idle gap between them.

---
 rtl/uart_transmitter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-entry holding register, clocked by the 16x baud clock.
// All outputs, including the serial line, come straight from flops.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 Clk_16_9600,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_EN,
  output logic                 TX_STATUS,
  output logic                 TX_BUSY,
  output logic                 UART_TX
);

  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W     = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;
  localparam int BIT_W     = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_reg;
  logic [CNT_W-1:0]     clk_cnt_reg;
  logic [BIT_W-1:0]     bit_cnt_reg;
  logic [DATA_BITS-1:0] hold_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic                 hold_valid_reg;
  logic                 tx_status_reg;
  logic                 tx_busy_reg;
  logic                 uart_tx_reg;
  logic                 accept;

  // tx_status_reg mirrors ~hold_valid_reg, so an accept never coincides with a transfer.
  assign accept     = TX_EN & tx_status_reg;
  assign shift_next = shift_reg >> 1;

  assign TX_STATUS = tx_status_reg;
  assign TX_BUSY   = tx_busy_reg;
  assign UART_TX   = uart_tx_reg;

  always_ff @(posedge Clk_16_9600) begin
    if (reset) begin
      state_reg      <= IDLE;
      clk_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      hold_reg       <= '0;
      shift_reg      <= '0;
      hold_valid_reg <= 1'b0;
      tx_status_reg  <= 1'b1;
      tx_busy_reg    <= 1'b0;
      uart_tx_reg    <= 1'b1;
    end else begin
      if (accept) begin
        hold_reg       <= TX_DATA;
        hold_valid_reg <= 1'b1;
        tx_status_reg  <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          uart_tx_reg <= 1'b1;
          clk_cnt_reg <= '0;
          bit_cnt_reg <= '0;
          if (hold_valid_reg) begin
            shift_reg      <= hold_reg;
            hold_valid_reg <= 1'b0;
            tx_status_reg  <= 1'b1;
            tx_busy_reg    <= 1'b1;
            uart_tx_reg    <= 1'b0;
            state_reg      <= START;
          end
        end

        START: begin
          if (clk_cnt_reg == BIT_LAST) begin
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            uart_tx_reg <= shift_reg[0];
            state_reg   <= DATA;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
          end
        end

        DATA: begin
          if (clk_cnt_reg == BIT_LAST) begin
            clk_cnt_reg <= '0;
            if (bit_cnt_reg == DATA_LAST) begin
              bit_cnt_reg <= '0;
              uart_tx_reg <= 1'b1;
              state_reg   <= STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
              shift_reg   <= shift_next;
              uart_tx_reg <= shift_next[0];
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
          end
        end

        STOP: begin
          if (clk_cnt_reg == STOP_LAST) begin
            clk_cnt_reg <= '0;
            // A held byte starts its frame immediately, with no idle bit in between.
            if (hold_valid_reg) begin
              shift_reg      <= hold_reg;
              hold_valid_reg <= 1'b0;
              tx_status_reg  <= 1'b1;
              uart_tx_reg    <= 1'b0;
              state_reg      <= START;
            end else begin
              tx_busy_reg <= 1'b0;
              uart_tx_reg <= 1'b1;
              state_reg   <= IDLE;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
